// File: rtl/phase_sampler.sv
// phase_sampler: decodes the spin of each coupled ring oscillator from its
// phase relative to reference oscillator 0. Each measurement spans one full
// reference period. The result is returned through a valid/ready handshake.
// Optional feature: define PHASE_SAMPLER_PERIOD_EN to add period_out, which
// reports the measured reference period alongside the spins.
module phase_sampler #(
   parameter int N  = 3,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  osc_in,
   input  logic          start,
   output logic          busy,
   output logic [N-1:0]  spin_out,
   output logic          spin_valid,
   input  logic          spin_ready,
`ifdef PHASE_SAMPLER_PERIOD_EN
   output logic [CW-1:0] period_out,
`endif
   output logic          timeout
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      MEASURE,
      DECIDE,
      DONE
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t                  state_q, state_d;
   logic [N-1:0]            sync1_q, sync1_d;
   logic [N-1:0]            sync2_q, sync2_d;
   logic [N-1:0]            hist_q, hist_d;
   logic [N-1:0]            osc_edge;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [N-1:1]            captured_q, captured_d;
   logic [N-1:1][CW-1:0]    phase_q, phase_d;
   logic [CW-1:0]           period_q, period_d;
   logic [N-1:0]            spin_q, spin_d;
   logic                    timeout_q, timeout_d;
   logic [N-1:1][CW+1:0]    phase4;
   logic [CW+1:0]           per_ext;
   logic [CW+1:0]           per3;
`ifdef PHASE_SAMPLER_PERIOD_EN
   logic [CW-1:0]           period_out_q, period_out_d;
`endif

   // Two-flop synchronizer plus history flop, same depth on every bit so relative phase is kept
   always_comb begin
      sync1_d = osc_in;
      sync2_d = sync1_q;
      hist_d  = sync2_q;
   end

   assign osc_edge = sync2_q & ~hist_q;

   // Widened operands for the anti-phase band test: 4*phase against P and 3*P
   always_comb begin
      phase4 = '0;
      for (int i = 1; i < N; i++) begin
         phase4[i] = {phase_q[i], 2'b00};
      end
      per_ext = {2'b00, period_q};
      per3    = per_ext + {per_ext[CW:0], 1'b0};
   end

   // Measurement sequencer: next state, counter, phase captures and decoded result
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      captured_d = captured_q;
      phase_d    = phase_q;
      period_d   = period_q;
      spin_d     = spin_q;
      timeout_d  = timeout_q;
`ifdef PHASE_SAMPLER_PERIOD_EN
      period_out_d = period_out_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
               cnt_d   = '0;
            end
         end
         ARM: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               spin_d    = '0;
`ifdef PHASE_SAMPLER_PERIOD_EN
               period_out_d = '0;
`endif
            end else if (osc_edge[0]) begin
               cnt_d      = '0;
               captured_d = '0;
               for (int i = 1; i < N; i++) begin
                  if (osc_edge[i]) begin
                     captured_d[i] = 1'b1;
                     phase_d[i]    = '0;
                  end
               end
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               spin_d    = '0;
`ifdef PHASE_SAMPLER_PERIOD_EN
               period_out_d = '0;
`endif
            end else begin
               for (int i = 1; i < N; i++) begin
                  if (osc_edge[i] && !captured_q[i]) begin
                     captured_d[i] = 1'b1;
                     phase_d[i]    = osc_edge[0] ? '0 : cnt_q + 1'b1;
                  end
               end
               if (osc_edge[0]) begin
                  period_d = cnt_q + 1'b1;
                  state_d  = DECIDE;
               end
            end
         end
         DECIDE: begin
            spin_d = '0;
            for (int i = 1; i < N; i++) begin
               spin_d[i] = captured_q[i] && (phase4[i] > per_ext) && (phase4[i] < per3);
            end
`ifdef PHASE_SAMPLER_PERIOD_EN
            period_out_d = period_q;
`endif
            state_d = DONE;
         end
         DONE: begin
            if (spin_ready) begin
               state_d   = IDLE;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any measurement in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sync1_q    <= '0;
         sync2_q    <= '0;
         hist_q     <= '0;
         cnt_q      <= '0;
         captured_q <= '0;
         phase_q    <= '0;
         period_q   <= '0;
         spin_q     <= '0;
         timeout_q  <= 1'b0;
`ifdef PHASE_SAMPLER_PERIOD_EN
         period_out_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         hist_q     <= hist_d;
         cnt_q      <= cnt_d;
         captured_q <= captured_d;
         phase_q    <= phase_d;
         period_q   <= period_d;
         spin_q     <= spin_d;
         timeout_q  <= timeout_d;
`ifdef PHASE_SAMPLER_PERIOD_EN
         period_out_q <= period_out_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE);
   assign spin_valid = (state_q == DONE);
   assign spin_out   = spin_q;
   assign timeout    = timeout_q;
`ifdef PHASE_SAMPLER_PERIOD_EN
   assign period_out = period_out_q;
`endif

endmodule

// File: tb/tb_phase_sampler.sv
// tb_phase_sampler: randomized scoreboard bench for phase_sampler.
// Synthetic oscillators are generated from a period, per-oscillator lags and
// enables. The expected spins come from the anti-phase band rule applied
// directly to those lags.
module tb_phase_sampler;

   localparam int N  = 3;
   localparam int CW = 8;

   typedef struct packed {
      logic          to;
      logic [N-1:0]  spin;
      logic [CW-1:0] per;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  osc_in;
   logic          start;
   logic          busy;
   logic [N-1:0]  spin_out;
   logic          spin_valid;
   logic          spin_ready;
   logic          timeout;
`ifdef PHASE_SAMPLER_PERIOD_EN
   logic [CW-1:0] period_out;
`endif

   exp_t          exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            osc_t = 20;
   int            osc_lag[N];
   logic [N-1:0]  osc_en = '0;
   int            ready_mode = 0;

   phase_sampler #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .osc_in     (osc_in),
      .start      (start),
      .busy       (busy),
      .spin_out   (spin_out),
      .spin_valid (spin_valid),
      .spin_ready (spin_ready),
`ifdef PHASE_SAMPLER_PERIOD_EN
      .period_out (period_out),
`endif
      .timeout    (timeout)
   );

   // Free-running sampling clock
   always #5 clk = ~clk;

   // Shared comparison routine: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference result from the band rule: spin when P < 4*lag < 3*P, no reference means timeout
   function automatic exp_t modelResult(input int t, input int l1, input int l2, input logic [N-1:0] en);
      exp_t r;
      int   lag[N];
      lag[0] = 0;
      lag[1] = l1;
      lag[2] = l2;
      r.to   = 1'b0;
      r.spin = '0;
      r.per  = t[CW-1:0];
      if (!en[0]) begin
         r.to  = 1'b1;
         r.per = '0;
      end else begin
         for (int i = 1; i < N; i++) begin
            r.spin[i] = en[i] && (4 * lag[i] > t) && (4 * lag[i] < 3 * t);
         end
      end
      return r;
   endfunction

   // Oscillator waveform generator and consumer ready driver, updated just after each rising edge
   initial begin
      int p;
      osc_in     = '0;
      spin_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         for (int i = 0; i < N; i++) begin
            p = ((cyc - osc_lag[i]) % osc_t + osc_t) % osc_t;
            osc_in[i] = osc_en[i] && (p < osc_t / 2);
         end
         case (ready_mode)
            0:       spin_ready = 1'($urandom_range(0, 1));
            1:       spin_ready = 1'b0;
            default: spin_ready = 1'b1;
         endcase
      end
   end

   // Monitor: every cycle a result is presented it must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && spin_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_valid: got spin_valid=1 expected no result at %0t", $time);
            end else begin
               e = exp_q[0];
               checkOutput("spin_out", 32'(spin_out), 32'(e.spin));
               checkOutput("timeout", 32'(timeout), 32'(e.to));
`ifdef PHASE_SAMPLER_PERIOD_EN
               checkOutput("period_out", 32'(period_out), 32'(e.per));
`endif
               if (spin_ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Waits (bounded) for the scoreboard to drain, then checks the post-handshake idle state
   task automatic waitDone(input exp_t e);
      int n = 0;
      while (exp_q.size() != 0 && n < 1500) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL result_wait: got no handshake after %0d cycles expected a result", n);
         exp_q.delete();
      end else begin
         #3;
         checkOutput("busy_after_hs", 32'(busy), 32'd0);
         checkOutput("valid_after_hs", 32'(spin_valid), 32'd0);
         checkOutput("spin_hold_after_hs", 32'(spin_out), 32'(e.spin));
         checkOutput("timeout_after_hs", 32'(timeout), 32'd0);
      end
   endtask

   // Single-cycle start request aligned just after a rising edge
   task automatic pulseStart();
      @(posedge clk);
      #2;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   // Configures the oscillators, lets the synchronizer settle, then launches one measurement
   task automatic launch(input int t, input int l1, input int l2, input logic [N-1:0] en, output exp_t e);
      osc_t      = t;
      osc_lag[0] = 0;
      osc_lag[1] = l1;
      osc_lag[2] = l2;
      osc_en     = en;
      repeat (5) @(posedge clk);
      e = modelResult(t, l1, l2, en);
      exp_q.push_back(e);
      pulseStart();
   endtask

   // Full measurement with scoreboard completion
   task automatic applyStimulus(input int t, input int l1, input int l2, input logic [N-1:0] en);
      exp_t e;
      launch(t, l1, l2, en, e);
      waitDone(e);
   endtask

   // Safety net so the bench can never hang
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, randomized cases, timeout, backpressure, mid-run reset
   initial begin
      exp_t e;
      int   t;
      int   n;
      logic prev;
      logic [N-1:0] en;
      rst   = 1'b1;
      start = 1'b0;
      osc_lag[0] = 0;
      osc_lag[1] = 0;
      osc_lag[2] = 0;
      repeat (3) @(posedge clk);
      #3;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_spin", 32'(spin_out), 32'd0);
      checkOutput("reset_valid", 32'(spin_valid), 32'd0);
      checkOutput("reset_timeout", 32'(timeout), 32'd0);
`ifdef PHASE_SAMPLER_PERIOD_EN
      checkOutput("reset_period", 32'(period_out), 32'd0);
`endif
      rst = 1'b0;

      applyStimulus(20, 0, 0, 3'b111);
      applyStimulus(20, 10, 0, 3'b111);
      applyStimulus(20, 4, 6, 3'b111);
      applyStimulus(20, 5, 15, 3'b111);
      applyStimulus(20, 6, 14, 3'b111);
      applyStimulus(40, 30, 20, 3'b011);

      for (int k = 0; k < 14; k++) begin
         t     = $urandom_range(8, 60);
         en[0] = ($urandom_range(0, 9) != 0);
         en[1] = ($urandom_range(0, 4) != 0);
         en[2] = ($urandom_range(0, 4) != 0);
         applyStimulus(t, $urandom_range(0, t - 1), $urandom_range(0, t - 1), en);
      end

      $display("[TB] timeout with silent oscillators and extra start pulses");
      launch(20, 0, 0, 3'b000, e);
      repeat (20) @(posedge clk);
      pulseStart();
      pulseStart();
      repeat (180) @(posedge clk);
      #3;
      checkOutput("timeout_still_busy", 32'(busy), 32'd1);
      checkOutput("timeout_not_early", 32'(spin_valid), 32'd0);
      waitDone(e);
      repeat (30) @(posedge clk);
      #3;
      checkOutput("no_queued_start", 32'(busy), 32'd0);

      $display("[TB] backpressure: ready held low");
      ready_mode = 1;
      launch(20, 10, 8, 3'b111, e);
      n = 0;
      while (!spin_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("hold_valid_seen", 32'(spin_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(spin_valid), 32'd1);
      end
      ready_mode = 2;
      waitDone(e);
      ready_mode = 0;

      $display("[TB] reset during measurement");
      launch(40, 20, 10, 3'b111, e);
      prev = osc_in[0];
      n    = 0;
      while (n < 100 && !(osc_in[0] && !prev)) begin
         prev = osc_in[0];
         @(posedge clk);
         #3;
         n++;
      end
      repeat (10) @(posedge clk);
      #3;
      checkOutput("midrun_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("midrun_rst_busy", 32'(busy), 32'd0);
      checkOutput("midrun_rst_spin", 32'(spin_out), 32'd0);
      checkOutput("midrun_rst_valid", 32'(spin_valid), 32'd0);
      checkOutput("midrun_rst_timeout", 32'(timeout), 32'd0);
`ifdef PHASE_SAMPLER_PERIOD_EN
      checkOutput("midrun_rst_period", 32'(period_out), 32'd0);
`endif
      @(posedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(40, 20, 10, 3'b111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
